// File: rtl/ddram_arb.sv
// Round-robin arbiter sharing one DDR3 wrapper channel (ch1_*) among NUM_CH
// one-shot req/ready clients; a single downstream transaction is outstanding.
module ddram_arb #(
  parameter int NUM_CH = 3
) (
  input  logic                 DDRAM_CLK,
  input  logic                 reset,
  input  logic [NUM_CH*28-1:0] cl_addr,
  input  logic [NUM_CH*64-1:0] cl_din,
  input  logic [NUM_CH-1:0]    cl_rnw,
  input  logic [NUM_CH-1:0]    cl_req,
  output logic [NUM_CH*64-1:0] cl_dout,
  output logic [NUM_CH-1:0]    cl_ready,
  output logic [27:0]          ch1_addr,
  output logic [63:0]          ch1_din,
  output logic                 ch1_rnw,
  output logic                 ch1_req,
  input  logic [63:0]          ch1_dout,
  input  logic                 ch1_ready
);

  // state | meaning
  // IDLE  | nothing downstream; grant the next pending client
  // BUSY  | ch1_req issued for client gnt_q, waiting for ch1_ready
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam int GW = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH);

  state_t                   state_q;
  logic [NUM_CH-1:0]        pend_q;
  logic [NUM_CH-1:0][27:0]  cap_addr_q;
  logic [NUM_CH-1:0][63:0]  cap_din_q;
  logic [NUM_CH-1:0]        cap_rnw_q;
  logic [NUM_CH-1:0][63:0]  dout_q;
  logic [NUM_CH-1:0]        ready_q;
  logic [GW-1:0]            gnt_q;
  logic [GW-1:0]            last_q;
  logic [27:0]              addr_q;
  logic [63:0]              din_q;
  logic                     rnw_q;
  logic                     req_q;

  logic                     grant_vld_d;
  logic [GW-1:0]            grant_idx_d;

  function automatic logic [GW-1:0] wrap_idx(input int v);
    return GW'(v % NUM_CH);
  endfunction

  // Scan starts just after the last winner, so the nearest pending client wins.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!grant_vld_d && pend_q[wrap_idx(int'(last_q) + i)]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = wrap_idx(int'(last_q) + i);
      end
    end
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      cap_addr_q <= '0;
      cap_din_q  <= '0;
      cap_rnw_q  <= '0;
      dout_q     <= '0;
      ready_q    <= '0;
      gnt_q      <= '0;
      last_q     <= GW'(NUM_CH - 1);
      addr_q     <= '0;
      din_q      <= '0;
      rnw_q      <= 1'b1;
      req_q      <= 1'b0;
    end else begin
      ready_q <= '0;
      req_q   <= 1'b0;
      // A client already pending (including the one in service) is not re-captured.
      for (int k = 0; k < NUM_CH; k++) begin
        if (cl_req[k] && !pend_q[k]) begin
          cap_addr_q[k] <= cl_addr[28*k +: 28];
          cap_din_q[k]  <= cl_din[64*k +: 64];
          cap_rnw_q[k]  <= cl_rnw[k];
          pend_q[k]     <= 1'b1;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            addr_q  <= cap_addr_q[grant_idx_d];
            din_q   <= cap_din_q[grant_idx_d];
            rnw_q   <= cap_rnw_q[grant_idx_d];
            req_q   <= 1'b1;
            gnt_q   <= grant_idx_d;
            last_q  <= grant_idx_d;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (ch1_ready) begin
            if (cap_rnw_q[gnt_q]) dout_q[gnt_q] <= ch1_dout;
            ready_q[gnt_q] <= 1'b1;
            pend_q[gnt_q]  <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cl_dout  = dout_q;
  assign cl_ready = ready_q;
  assign ch1_addr = addr_q;
  assign ch1_din  = din_q;
  assign ch1_rnw  = rnw_q;
  assign ch1_req  = req_q;

endmodule
